// File: rtl/seq_add_sub.sv
// seq_add_sub: serial two's-complement adder/subtractor.
// Operands are consumed CHUNK bits per clock, LSB chunk first. A single
// registered carry links the chunks. Results appear on o_sum/o_cout/o_ovf
// only on completion edges.
module seq_add_sub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_sub,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  // WIDTH must be at least 2 and an integer multiple of CHUNK.
  localparam int STEPS = WIDTH / CHUNK;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  stateT            r_state;
  stateT            w_nextState;

  logic [WIDTH-1:0] r_aShift;
  logic [WIDTH-1:0] r_bShift;
  logic [WIDTH-1:0] r_resShift;
  logic             r_carry;
  logic [CNT_W-1:0] r_count;

  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [CHUNK:0]   w_chunkAdd;
  logic             w_carryIntoMsb;
  logic [WIDTH-1:0] w_resNext;
  logic             w_accept;
  logic             w_lastStep;

  // A new operation can only be taken when no operation is in flight.
  assign w_accept   = i_start && ((r_state == IDLE) || (r_state == DONE));
  assign w_lastStep = (r_state == RUN) && (r_count == LAST_STEP);

  // Chunk adder: low CHUNK bits of both operand shifters plus the carry.
  // The carry into the top bit of the chunk is recovered from the sum bit,
  // which also works for CHUNK=1 where it is simply the carry register.
  // New result bits enter the result shifter from the top, so after STEPS
  // chunks the LSB chunk has arrived at the bottom.
  always_comb begin
    w_chunkAdd     = {1'b0, r_aShift[CHUNK-1:0]} + {1'b0, r_bShift[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_carry};
    w_carryIntoMsb = w_chunkAdd[CHUNK-1] ^ r_aShift[CHUNK-1] ^ r_bShift[CHUNK-1];
    w_resNext      = (r_resShift >> CHUNK)
                   | (WIDTH'(w_chunkAdd[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  // State register; reset discards any operation in progress.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: DONE lasts one cycle and can accept back-to-back.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (i_start) w_nextState = RUN;
      RUN:     if (r_count == LAST_STEP) w_nextState = DONE;
      DONE:    w_nextState = i_start ? RUN : IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Serial datapath: load on accept, process one chunk per RUN cycle and
  // publish sum/cout/ovf only on the edge that processes the last chunk.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_aShift   <= '0;
      r_bShift   <= '0;
      r_resShift <= '0;
      r_carry    <= 1'b0;
      r_count    <= '0;
      r_sum      <= '0;
      r_cout     <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (w_accept) begin
      r_aShift   <= i_a;
      r_bShift   <= i_b ^ {WIDTH{i_sub}};
      r_carry    <= i_sub;
      r_count    <= '0;
      r_resShift <= '0;
    end else if (r_state == RUN) begin
      r_aShift   <= r_aShift >> CHUNK;
      r_bShift   <= r_bShift >> CHUNK;
      r_resShift <= w_resNext;
      r_carry    <= w_chunkAdd[CHUNK];
      r_count    <= r_count + CNT_W'(1);
      if (w_lastStep) begin
        r_sum  <= w_resNext;
        r_cout <= w_chunkAdd[CHUNK];
        r_ovf  <= w_carryIntoMsb ^ w_chunkAdd[CHUNK];
      end
    end
  end

  assign o_busy = (r_state == RUN);
  assign o_done = (r_state == DONE);
  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_seq_add_sub.sv
// tb_seq_add_sub: four instances (CHUNK = 1, 2, 4, 8; WIDTH = 8) checked every
// cycle against a timestamp-based behavioural model, plus directed cases.
module tb_seq_add_sub;

  logic       clk;
  logic       rst;
  logic       startS [4];
  logic       subS   [4];
  logic [7:0] aS     [4];
  logic [7:0] bS     [4];
  logic       busyO  [4];
  logic       doneO  [4];
  logic [7:0] sumO   [4];
  logic       coutO  [4];
  logic       ovfO   [4];

  int checkCount = 0;
  int passCount  = 0;
  int cyc        = 0;

  // Model state: per instance, the in-flight operation (accept edge, completion
  // edge, pending result) and the currently visible result.
  bit         mHasOp    [4];
  int         mStart    [4];
  int         mDoneEdge [4];
  logic [9:0] mPend     [4];
  logic [9:0] mVis      [4];
  int         acceptCnt [4];

  seq_add_sub #(.WIDTH(8), .CHUNK(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(startS[0]), .i_sub(subS[0]),
    .i_a(aS[0]), .i_b(bS[0]), .o_busy(busyO[0]), .o_done(doneO[0]),
    .o_sum(sumO[0]), .o_cout(coutO[0]), .o_ovf(ovfO[0]));

  seq_add_sub #(.WIDTH(8), .CHUNK(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(startS[1]), .i_sub(subS[1]),
    .i_a(aS[1]), .i_b(bS[1]), .o_busy(busyO[1]), .o_done(doneO[1]),
    .o_sum(sumO[1]), .o_cout(coutO[1]), .o_ovf(ovfO[1]));

  seq_add_sub #(.WIDTH(8), .CHUNK(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_start(startS[2]), .i_sub(subS[2]),
    .i_a(aS[2]), .i_b(bS[2]), .o_busy(busyO[2]), .o_done(doneO[2]),
    .o_sum(sumO[2]), .o_cout(coutO[2]), .o_ovf(ovfO[2]));

  seq_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(startS[3]), .i_sub(subS[3]),
    .i_a(aS[3]), .i_b(bS[3]), .o_busy(busyO[3]), .o_done(doneO[3]),
    .o_sum(sumO[3]), .o_cout(coutO[3]), .o_ovf(ovfO[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Plain-arithmetic reference: returns {ovf, cout, sum}.
  function automatic logic [9:0] refCalc(input logic [7:0] a, input logic [7:0] b,
                                         input logic s);
    logic [7:0] r;
    logic       c;
    logic       v;
    if (s) begin
      r = a - b;
      c = (a >= b);
      v = (a[7] != b[7]) && (r[7] != a[7]);
    end else begin
      {c, r} = {1'b0, a} + {1'b0, b};
      v = (a[7] == b[7]) && (r[7] != a[7]);
    end
    return {v, c, r};
  endfunction

  task automatic checkOutput(input string name, input int k, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s[%0d]: actual=0x%0h expected=0x%0h", name, k, act, exp);
  endtask

  task automatic checkResult(input int k, input string name, input logic [7:0] s,
                             input logic c, input logic v);
    checkOutput({name, "Sum"},  k, int'(sumO[k]),  int'(s));
    checkOutput({name, "Cout"}, k, int'(coutO[k]), int'(c));
    checkOutput({name, "Ovf"},  k, int'(ovfO[k]),  int'(v));
  endtask

  // Present one operation for one edge; returns the edge index that accepted it.
  task automatic applyStimulus(input int k, input logic [7:0] a, input logic [7:0] b,
                               input logic s, output int acc);
    @(negedge clk);
    startS[k] = 1'b1;
    aS[k]     = a;
    bS[k]     = b;
    subS[k]   = s;
    @(negedge clk);
    acc       = cyc;
    startS[k] = 1'b0;
  endtask

  // Wait (bounded) for done; counts busy cycles seen on the way.
  task automatic waitDone(input int k, output int doneEdge, output int busyCnt);
    bit got = 1'b0;
    busyCnt = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      if (doneO[k]) got = 1'b1;
      else begin
        if (busyO[k]) busyCnt++;
        @(negedge clk);
      end
    end
    checkOutput("doneSeen", k, int'(got), 1);
    doneEdge = cyc;
  endtask

  // Behavioural model: advances on clock edges, cleared by reset.
  initial begin
    for (int k = 0; k < 4; k++) begin
      mHasOp[k] = 1'b0; mStart[k] = 0; mDoneEdge[k] = 0;
      mPend[k] = '0; mVis[k] = '0; acceptCnt[k] = 0;
    end
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        for (int k = 0; k < 4; k++) begin
          mHasOp[k] = 1'b0;
          mVis[k]   = '0;
        end
      end else begin
        cyc++;
        for (int k = 0; k < 4; k++) begin
          if (mHasOp[k] && cyc == mDoneEdge[k]) mVis[k] = mPend[k];
          if (startS[k] && (!mHasOp[k] || cyc > mDoneEdge[k])) begin
            mPend[k]     = refCalc(aS[k], bS[k], subS[k]);
            mStart[k]    = cyc;
            mDoneEdge[k] = cyc + (8 >> k);
            mHasOp[k]    = 1'b1;
            acceptCnt[k]++;
          end
        end
      end
    end
  end

  // Compare every instance against the model on every falling edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        checkOutput("cmpBusy", k, int'(busyO[k]),
                    int'(mHasOp[k] && cyc >= mStart[k] && cyc < mDoneEdge[k]));
        checkOutput("cmpDone", k, int'(doneO[k]), int'(mHasOp[k] && cyc == mDoneEdge[k]));
        checkOutput("cmpSum",  k, int'(sumO[k]),  int'(mVis[k][7:0]));
        checkOutput("cmpCout", k, int'(coutO[k]), int'(mVis[k][8]));
        checkOutput("cmpOvf",  k, int'(ovfO[k]),  int'(mVis[k][9]));
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  acc;
    int  de;
    int  bc;
    int  t1;
    int  t2;
    int  n;
    int  cycles;
    bit  enough;

    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      startS[k] = 1'b0; subS[k] = 1'b0; aS[k] = '0; bS[k] = '0;
    end
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      checkResult(k, "reset", 8'h00, 1'b0, 1'b0);
      checkOutput("resetBusy", k, int'(busyO[k]), 0);
      checkOutput("resetDone", k, int'(doneO[k]), 0);
    end
    checkOutput("modelPinAdd", 0, int'(refCalc(8'h5A, 8'h3C, 1'b0)), 'h296);
    checkOutput("modelPinSub", 0, int'(refCalc(8'h80, 8'h01, 1'b1)), 'h37F);
    rst = 1'b0;

    $display("[TB] directed CHUNK=1");
    applyStimulus(0, 8'h5A, 8'h3C, 1'b0, acc);
    waitDone(0, de, bc);
    checkOutput("addLatency", 0, de - acc, 8);
    checkOutput("addBusyCycles", 0, bc, 8);
    checkResult(0, "add5A3C", 8'h96, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("donePulseWidth", 0, int'(doneO[0]), 0);

    applyStimulus(0, 8'h10, 8'h20, 1'b1, acc);
    waitDone(0, de, bc);
    checkResult(0, "sub1020", 8'hF0, 1'b0, 1'b0);
    applyStimulus(0, 8'h80, 8'h01, 1'b1, acc);
    waitDone(0, de, bc);
    checkResult(0, "sub8001", 8'h7F, 1'b1, 1'b1);

    applyStimulus(0, 8'hFF, 8'h01, 1'b0, acc);
    @(negedge clk);
    @(negedge clk);
    aS[0] = 8'h55;
    startS[0] = 1'b1;
    @(negedge clk);
    startS[0] = 1'b0;
    waitDone(0, de, bc);
    checkOutput("ignoreLatency", 0, de - acc, 8);
    checkResult(0, "addFF01", 8'h00, 1'b1, 1'b0);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (doneO[0]) n++;
    end
    checkOutput("noExtraDone", 0, n, 0);

    applyStimulus(0, 8'h7F, 8'h01, 1'b0, acc);
    repeat (4) @(negedge clk);
    checkOutput("busyBeforeReset", 0, int'(busyO[0]), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkResult(0, "asyncReset", 8'h00, 1'b0, 1'b0);
    checkOutput("asyncResetBusy", 0, int'(busyO[0]), 0);
    checkOutput("asyncResetDone", 0, int'(doneO[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 8'h01, 8'h01, 1'b0, acc);
    waitDone(0, de, bc);
    checkResult(0, "add0101", 8'h02, 1'b0, 1'b0);

    @(negedge clk);
    startS[0] = 1'b1; aS[0] = 8'h01; bS[0] = 8'h02; subS[0] = 1'b0;
    @(negedge clk);
    acc = cyc;
    waitDone(0, t1, bc);
    checkOutput("b2bLatency", 0, t1 - acc, 8);
    checkResult(0, "b2bFirst", 8'h03, 1'b0, 1'b0);
    aS[0] = 8'h03; bS[0] = 8'h03; subS[0] = 1'b1;
    @(negedge clk);
    checkOutput("b2bNoGap", 0, int'(busyO[0]), 1);
    waitDone(0, t2, bc);
    startS[0] = 1'b0;
    checkOutput("b2bSpacing", 0, t2 - t1, 9);
    checkResult(0, "b2bSecond", 8'h00, 1'b1, 1'b0);

    $display("[TB] directed CHUNK=4");
    applyStimulus(2, 8'h7F, 8'h01, 1'b0, acc);
    waitDone(2, de, bc);
    checkOutput("chunk4Latency", 2, de - acc, 2);
    checkResult(2, "chunk4Add7F01", 8'h80, 1'b0, 1'b1);

    $display("[TB] random sweep");
    for (int k = 0; k < 4; k++) acceptCnt[k] = 0;
    cycles = 0;
    enough = 1'b0;
    while (!enough && cycles < 15000) begin
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
        startS[k] = ($urandom_range(0, 9) < 8);
        aS[k]     = 8'($urandom);
        bS[k]     = 8'($urandom);
        subS[k]   = 1'($urandom);
      end
      cycles++;
      enough = 1'b1;
      for (int k = 0; k < 4; k++) if (acceptCnt[k] < 1000) enough = 1'b0;
    end
    checkOutput("sweepComplete", 0, int'(enough), 1);
    for (int k = 0; k < 4; k++) startS[k] = 1'b0;
    repeat (20) @(negedge clk);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/seq_add_sub.md
Name: seq_add_sub

Overview:
Multi-cycle, parametrised two's-complement adder/subtractor. It processes operands CHUNK bits per clock, LSB chunk first, using one registered carry between chunks. Start/done handshake, add/subtract mode, unsigned carry-out and signed overflow flags. Generalises the fixed 3-bit ripple adder into a small-area serial datapath for wide operands in lab designs.

Parameters:
WIDTH, 8, operand/result width in bits; must be ≥ 2.
CHUNK, 1, bits added per clock; WIDTH must be an integer multiple of CHUNK. STEPS = WIDTH/CHUNK.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
start  input  1  request a new operation; sampled only in IDLE or DONE
sub  input  1  0 = A+B, 1 = A−B; sampled with start
a  input  WIDTH  operand A; sampled with start
b  input  WIDTH  operand B; sampled with start
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse: result registers just updated
sum  output  WIDTH  result, held until the next completion
cout  output  1  carry out of MSB; for sub, 1 = no borrow (A ≥ B unsigned)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (async, any state, mid-operation included): state=IDLE; sum=0, cout=0, ovf=0, done=0, busy=0; step counter, carry and shift registers cleared. The interrupted operation is discarded. No partial result is ever visible.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 at edge → latch a, b^{WIDTH{sub}}, carry←sub, count←0 → RUN.
  - RUN: at each edge, add the low CHUNK bits of the A and B shift registers plus carry. Shift both operands right by CHUNK. Shift the CHUNK result bits into the top of the result shift register. Update carry. count++. On the edge processing chunk STEPS−1 → DONE.
  - DONE: lasts exactly one cycle, done=1. Next edge: start=1 → behave as the IDLE accept (back-to-back), else → IDLE.
- The completion edge loads the result shift register into sum and loads cout and ovf. Carry into the MSB comes from within the final chunk (CHUNK=1: the incoming carry register). sum/cout/ovf change only on completion edges and reset.
- Latency: start sampled at edge E0 → done high in the cycle after edge E_STEPS (WIDTH=8, CHUNK=1: 8 edges). Throughput: one result per STEPS+1 cycles. Start held continuously gives one result every STEPS+1 cycles.
- start during RUN is ignored (no queueing). Changes to a/b/sub after the accepting edge are ignored.
- busy=1 exactly in RUN. busy and done are never high together.
- Arithmetic is modulo 2^WIDTH. cout and ovf follow the standard full-adder chain, so results are bit-identical to a combinational WIDTH-bit ripple adder with carry-in = sub and B inverted when sub=1.

Test Plan:
- WIDTH=8, CHUNK=1, add 0x5A+0x3C → sum=0x96, cout=0, ovf=1. done high for exactly one cycle, after edge 8 from start. busy high for 8 cycles.
- Sub 0x10−0x20 → sum=0xF0, cout=0, ovf=0. Sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1.
- Add 0xFF+0x01 → sum=0x00, cout=1, ovf=0. Change a to 0x55 and pulse start during RUN → result unaffected, no extra done.
- Assert rst at RUN step 4 of 0x7F+0x01 → all outputs 0 immediately (async). Then 0x01+0x01 → sum=0x02, cout=0, ovf=0.
- Hold start high with new operands loaded each DONE cycle: 0x01+0x02, then 0x03−0x03 → sums 0x03, then 0x00 with cout=1. done pulses 9 cycles apart, no IDLE gap.
- WIDTH=8, CHUNK=4: 0x7F+0x01 → sum=0x80, cout=0, ovf=1, done after edge 2. Random 1000-vector sweep against a combinational reference for CHUNK ∈ {1,2,4,8}.
